// File: rtl/imm_extend_stage.sv
// Registered immediate extender (sign / zero / upper / branch) behind a
// valid/ready interface with a two-entry skid buffer; InReady never sees OutReady.
module imm_extend_stage #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [IN_WIDTH-1:0]  InData,
  input  logic [1:0]           InMode,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [OUT_WIDTH-1:0] OutData
);

  localparam int unsigned K = OUT_WIDTH - IN_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   main_q, main_d;
  logic [OUT_WIDTH-1:0]   skid_q, skid_d;
  logic [OUT_WIDTH-1:0]   sext_c;
  logic [OUT_WIDTH-1:0]   ext_c;
  logic                   in_fire_c;
  logic                   out_fire_c;

  // Extension of the immediate currently presented upstream.
  always_comb begin
    sext_c = {{K{InData[IN_WIDTH-1]}}, InData};
    ext_c  = sext_c;
    case (InMode)
      2'b00:   ext_c = sext_c;
      2'b01:   ext_c = {{K{1'b0}}, InData};
      2'b10:   ext_c = {InData, {K{1'b0}}};
      default: ext_c = sext_c << 2;
    endcase
  end

  assign InReady    = !Reset && (state_q != ST_FULL);
  assign OutValid   = (state_q != ST_EMPTY);
  assign OutData    = main_q;
  assign in_fire_c  = InValid && InReady;
  assign out_fire_c = OutValid && OutReady;

  // Next-state and buffer steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          main_d  = ext_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = ext_c;
        end else if (in_fire_c) begin
          skid_d  = ext_c;
          state_d = ST_FULL;
        end else if (out_fire_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire_c) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops occupancy and any same-cycle capture; stale data is harmless.
    if (Flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
